// File: rtl/jpeg_block_scheduler.sv
// rtl/jpeg_block_scheduler.sv - round-robin block scheduler for a shared fixed-latency JPEG pipeline
//
// Purpose:
//   Shares one fixed-latency 8x8 compression pipeline among NUM_REQ block
//   sources. Grants requests in rotating-priority order, emits a one-cycle
//   launch strobe with the source index for the external pixel mux, and
//   tracks in-flight blocks through a tag delay line so each pipeline result
//   is flagged with its owning source in the cycle it becomes valid.
//
// Ports:
//   i_clk              clock, all logic on the rising edge
//   i_reset            synchronous, active-high reset
//   i_enable           1 = new grants allowed; 0 = pause issuing, in-flight drains
//   i_req              per-source block-pending level, held until granted
//   o_grant            combinational one-hot grant; handshake = req & grant at an edge
//   o_launch           registered strobe; pipeline samples muxed pixels this cycle
//   o_launch_id        registered source index for the pixel mux
//   o_res_valid        registered strobe; pipeline output belongs to o_res_id
//   o_res_id           source of the current result (holds when no result)
//   o_inflight_count   launched blocks whose result has not yet appeared
//   o_idle             nothing in flight, no launch, no grant

module jpeg_block_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int LATENCY   = 5,
  parameter int MIN_GAP   = 1,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [NUM_REQ-1:0]   i_req,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_launch,
  output logic [ID_WIDTH-1:0]  o_launch_id,
  output logic                 o_res_valid,
  output logic [ID_WIDTH-1:0]  o_res_id,
  output logic [CNT_WIDTH-1:0] o_inflight_count,
  output logic                 o_idle
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  logic [ID_WIDTH-1:0]  r_rr_ptr;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_launch;
  logic [ID_WIDTH-1:0]  r_launch_id;
  logic [LATENCY-1:0]   r_tag_v;
  logic [ID_WIDTH-1:0]  r_tag_id [LATENCY];
  logic [CNT_WIDTH-1:0] r_inflight;

  logic                 w_issue;
  logic [ID_WIDTH-1:0]  w_grant_idx;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_handshake;

  // First set request searching upward from ptr+1, wrapping modulo NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH-1:0] pick;
    logic                found;
    int                  idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Grant depends only on req, enable, reset and internal state -- never on
  // launch or res_valid -- so the pixel mux cannot close a combinational loop.
  always_comb begin
    w_issue     = !i_reset && i_enable && (|i_req) && (r_gap_cnt == '0);
    w_grant_idx = rr_pick(i_req, r_rr_ptr);
    w_grant     = '0;
    if (w_issue) begin
      w_grant[w_grant_idx] = 1'b1;
    end
    w_handshake = |(i_req & w_grant);
  end

  // Arbitration pointer and launch spacing.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr  <= ID_WIDTH'(NUM_REQ - 1);
      r_gap_cnt <= '0;
    end else if (w_handshake) begin
      r_rr_ptr  <= w_grant_idx;
      r_gap_cnt <= GAP_W'(MIN_GAP - 1);
    end else if (r_gap_cnt != '0) begin
      r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  // Launch strobe; launch_id holds its last value between launches.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_launch    <= 1'b0;
      r_launch_id <= '0;
    end else begin
      r_launch <= w_handshake;
      if (w_handshake) begin
        r_launch_id <= w_grant_idx;
      end
    end
  end

  // Tag delay line. Ids only advance alongside a valid bit, so the output
  // stage id keeps the last result's source while res_valid is low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      r_tag_v[0] <= r_launch;
      if (r_launch) begin
        r_tag_id[0] <= r_launch_id;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        if (r_tag_v[i-1]) begin
          r_tag_id[i] <= r_tag_id[i-1];
        end
      end
    end
  end

  // In-flight counter: a launch and a result on the same edge cancel out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_inflight <= '0;
    end else begin
      case ({r_launch, r_tag_v[LATENCY-1]})
        2'b10:   r_inflight <= r_inflight + CNT_WIDTH'(1);
        2'b01:   r_inflight <= r_inflight - CNT_WIDTH'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign o_grant          = w_grant;
  assign o_launch         = r_launch;
  assign o_launch_id      = r_launch_id;
  assign o_res_valid      = r_tag_v[LATENCY-1];
  assign o_res_id         = r_tag_id[LATENCY-1];
  assign o_inflight_count = r_inflight;
  assign o_idle           = (r_inflight == '0) && !r_launch && !(|w_grant);

endmodule
